// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus sequencer: state encoding, defaults, idle strobes.
package rtc_bus_pkg;

  localparam int DW_DEFAULT      = 8;
  localparam int T_PHASE_DEFAULT = 4;

  // {CS_n, AD_n, RD_n, WR_n} with every strobe inactive
  localparam logic [3:0] STROBE_IDLE = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_ADDR_SETUP  = 3'd1,
    S_ADDR_STROBE = 3'd2,
    S_ADDR_HOLD   = 3'd3,
    S_DATA_SETUP  = 3'd4,
    S_DATA_STROBE = 3'd5,
    S_DATA_HOLD   = 3'd6,
    S_DONE        = 3'd7
  } state_t;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Phase counter for the RTC bus sequencer: counts 0..T_PHASE-1 and wraps, o_tc on the last count.
module rtc_phase_timer
  import rtc_bus_pkg::*;
#(
  parameter int T_PHASE = T_PHASE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_tc
);

  localparam int              CW   = cnt_width(T_PHASE);
  localparam logic [CW-1:0]   LAST = CW'(T_PHASE - 1);

  logic [CW-1:0] r_count;

  assign o_tc = (r_count == LAST);

  // Wrapping on terminal count keeps the counter aligned to each new phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear || o_tc) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Drives one multiplexed address/data bus cycle to the RTC chip per accepted command.
// Define RTC_BUS_SEQ_CMD_QUEUE_EN to add a one-entry pending-command queue and q_full.
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int DW      = DW_DEFAULT,
  parameter int T_PHASE = T_PHASE_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          wr_nrd,
  input  logic [DW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rdata,
  input  logic [DW-1:0] rtc_bus_in,
  output logic [DW-1:0] bus_out,
  output logic          EN_SS,
  output logic          CS_n,
  output logic          AD_n,
  output logic          RD_n,
  output logic          WR_n
`ifdef RTC_BUS_SEQ_CMD_QUEUE_EN
  ,
  output logic          q_full
`endif
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_tc;
  logic          w_clear;
  logic          w_accept;
  logic          w_launch_q;
  logic          r_cmd_wr;
  logic [DW-1:0] r_cmd_addr;
  logic [DW-1:0] r_cmd_wdata;
  logic          w_cmd_wr_nxt;
  logic [DW-1:0] w_cmd_addr_nxt;
  logic [DW-1:0] w_cmd_wdata_nxt;
  logic [3:0]    w_strb;
  logic          w_en_ss;
  logic          w_busy;
  logic          w_done;
  logic [DW-1:0] w_bus;

  assign w_clear = (r_state == S_IDLE) || (r_state == S_DONE);

  rtc_phase_timer #(
    .T_PHASE(T_PHASE)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clear),
    .o_tc    (w_tc)
  );

`ifdef RTC_BUS_SEQ_CMD_QUEUE_EN
  logic          r_q_full;
  logic          r_q_wr;
  logic [DW-1:0] r_q_addr;
  logic [DW-1:0] r_q_wdata;

  // A queued command launches from DONE (back to back) or, if captured during DONE, from IDLE
  assign w_launch_q = r_q_full && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_accept   = (r_state == S_IDLE) && start && !r_q_full;
  assign q_full     = r_q_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_full  <= 1'b0;
      r_q_wr    <= 1'b0;
      r_q_addr  <= '0;
      r_q_wdata <= '0;
    end else if (w_launch_q) begin
      r_q_full <= 1'b0;
    end else if (start && (r_state != S_IDLE) && !r_q_full) begin
      r_q_full  <= 1'b1;
      r_q_wr    <= wr_nrd;
      r_q_addr  <= addr;
      r_q_wdata <= wdata;
    end
  end
`else
  assign w_launch_q = 1'b0;
  assign w_accept   = (r_state == S_IDLE) && start;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:        if (w_accept || w_launch_q) w_state_nxt = S_ADDR_SETUP;
      S_ADDR_SETUP:  if (w_tc) w_state_nxt = S_ADDR_STROBE;
      S_ADDR_STROBE: if (w_tc) w_state_nxt = S_ADDR_HOLD;
      S_ADDR_HOLD:   if (w_tc) w_state_nxt = S_DATA_SETUP;
      S_DATA_SETUP:  if (w_tc) w_state_nxt = S_DATA_STROBE;
      S_DATA_STROBE: if (w_tc) w_state_nxt = S_DATA_HOLD;
      S_DATA_HOLD:   if (w_tc) w_state_nxt = S_DONE;
      S_DONE:        w_state_nxt = w_launch_q ? S_ADDR_SETUP : S_IDLE;
      default:       w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cmd_wr_nxt    = r_cmd_wr;
    w_cmd_addr_nxt  = r_cmd_addr;
    w_cmd_wdata_nxt = r_cmd_wdata;
    if (w_accept) begin
      w_cmd_wr_nxt    = wr_nrd;
      w_cmd_addr_nxt  = addr;
      w_cmd_wdata_nxt = wdata;
    end
`ifdef RTC_BUS_SEQ_CMD_QUEUE_EN
    else if (w_launch_q) begin
      w_cmd_wr_nxt    = r_q_wr;
      w_cmd_addr_nxt  = r_q_addr;
      w_cmd_wdata_nxt = r_q_wdata;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_wr    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
    end else begin
      r_cmd_wr    <= w_cmd_wr_nxt;
      r_cmd_addr  <= w_cmd_addr_nxt;
      r_cmd_wdata <= w_cmd_wdata_nxt;
    end
  end

  // Outputs decoded from the next state so every pin comes straight from a flop.
  // w_strb is {CS_n, AD_n, RD_n, WR_n}; reads release the bus for the whole data half.
  always_comb begin
    w_strb  = STROBE_IDLE;
    w_en_ss = 1'b0;
    w_bus   = '0;
    w_busy  = (w_state_nxt != S_IDLE);
    w_done  = (w_state_nxt == S_DONE);
    unique case (w_state_nxt)
      S_ADDR_SETUP: begin
        w_strb  = 4'b0011;
        w_en_ss = 1'b1;
        w_bus   = w_cmd_addr_nxt;
      end
      S_ADDR_STROBE: begin
        w_strb  = 4'b0010;
        w_en_ss = 1'b1;
        w_bus   = w_cmd_addr_nxt;
      end
      S_ADDR_HOLD: begin
        w_en_ss = 1'b1;
        w_bus   = w_cmd_addr_nxt;
      end
      S_DATA_SETUP: begin
        w_strb  = 4'b0111;
        w_en_ss = w_cmd_wr_nxt;
        w_bus   = w_cmd_wr_nxt ? w_cmd_wdata_nxt : '0;
      end
      S_DATA_STROBE: begin
        w_strb  = w_cmd_wr_nxt ? 4'b0110 : 4'b0101;
        w_en_ss = w_cmd_wr_nxt;
        w_bus   = w_cmd_wr_nxt ? w_cmd_wdata_nxt : '0;
      end
      S_DATA_HOLD: begin
        w_en_ss = w_cmd_wr_nxt;
        w_bus   = w_cmd_wr_nxt ? w_cmd_wdata_nxt : '0;
      end
      default: begin
        w_strb  = STROBE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {CS_n, AD_n, RD_n, WR_n} <= STROBE_IDLE;
      EN_SS   <= 1'b0;
      bus_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      {CS_n, AD_n, RD_n, WR_n} <= w_strb;
      EN_SS   <= w_en_ss;
      bus_out <= w_bus;
      busy    <= w_busy;
      done    <= w_done;
    end
  end

  // Sample on the final strobe cycle, while RD_n is still low at the pad
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if ((r_state == S_DATA_STROBE) && w_tc && !r_cmd_wr) begin
      rdata <= rtc_bus_in;
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Self-checking bench for rtc_bus_sequencer: a T_PHASE=4 and a T_PHASE=1 instance against a cycle-indexed model.
module tb_rtc_bus_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start0, start1, wr_nrd;
  logic [7:0] addr, wdata;
  logic       busy0, done0, en0, cs0, ad0, rd0, wr0;
  logic       busy1, done1, en1, cs1, ad1, rd1, wr1;
  logic [7:0] rdata0, bus0, bin0;
  logic [7:0] rdata1, bus1, bin1;
`ifdef RTC_BUS_SEQ_CMD_QUEUE_EN
  logic       q_full0, q_full1;
`endif

  logic [7:0] cur_rv [2];
  logic [7:0] exp_rd [2];
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         sel;
    logic       wr;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] rv;
    int         bs;
  } cmd_t;

  // RTC pad model: drives the read value while RD_n is low, its complement otherwise
  always_comb bin0 = rd0 ? ~cur_rv[0] : cur_rv[0];
  always_comb bin1 = rd1 ? ~cur_rv[1] : cur_rv[1];

  rtc_bus_sequencer #(.DW(8), .T_PHASE(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .wr_nrd(wr_nrd), .addr(addr), .wdata(wdata),
    .busy(busy0), .done(done0), .rdata(rdata0), .rtc_bus_in(bin0), .bus_out(bus0),
    .EN_SS(en0), .CS_n(cs0), .AD_n(ad0), .RD_n(rd0), .WR_n(wr0)
`ifdef RTC_BUS_SEQ_CMD_QUEUE_EN
    , .q_full(q_full0)
`endif
  );

  rtc_bus_sequencer #(.DW(8), .T_PHASE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .wr_nrd(wr_nrd), .addr(addr), .wdata(wdata),
    .busy(busy1), .done(done1), .rdata(rdata1), .rtc_bus_in(bin1), .bus_out(bus1),
    .EN_SS(en1), .CS_n(cs1), .AD_n(ad1), .RD_n(rd1), .WR_n(wr1)
`ifdef RTC_BUS_SEQ_CMD_QUEUE_EN
    , .q_full(q_full1)
`endif
  );

  // Expected {busy, done, EN_SS, CS_n, AD_n, RD_n, WR_n, bus_out} in cycle k after acceptance at edge 0
  function automatic logic [14:0] exp_out(input int tp, input int k, input logic wr,
                                          input logic [7:0] a, input logic [7:0] d);
    logic [6:0] c;
    logic [7:0] b;
    int p;
    c = 7'b0001111;
    b = 8'h00;
    if (k >= 1 && k <= 6 * tp) begin
      p = (k - 1) / tp;
      case (p)
        0: begin c = 7'b1010011; b = a; end
        1: begin c = 7'b1010010; b = a; end
        2: begin c = 7'b1011111; b = a; end
        3: begin c = wr ? 7'b1010111 : 7'b1000111; b = wr ? d : 8'h00; end
        4: begin c = wr ? 7'b1010110 : 7'b1000101; b = wr ? d : 8'h00; end
        default: begin c = wr ? 7'b1011111 : 7'b1001111; b = wr ? d : 8'h00; end
      endcase
    end else if (k == 6 * tp + 1) begin
      c = 7'b1101111;
    end
    return {c, b};
  endfunction

  task automatic test_reset;
    logic [6:0] oc;
    logic [7:0] ob, ord;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    wr_nrd = 1'b0; addr = 8'h00; wdata = 8'h00;
    cur_rv[0] = 8'h00; cur_rv[1] = 8'h00;
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      if (s == 0) begin oc = {busy0, done0, en0, cs0, ad0, rd0, wr0}; ob = bus0; ord = rdata0; end
      else        begin oc = {busy1, done1, en1, cs1, ad1, rd1, wr1}; ob = bus1; ord = rdata1; end
      n_checks++;
      if (oc !== 7'b0001111) begin n_fail++; $display("FAIL reset_ctrl dut%0d: got %b expected 0001111", s, oc); end
      n_checks++;
      if (ob !== 8'h00) begin n_fail++; $display("FAIL reset_bus dut%0d: got %h expected 00", s, ob); end
      n_checks++;
      if (ord !== 8'h00) begin n_fail++; $display("FAIL reset_rdata dut%0d: got %h expected 00", s, ord); end
    end
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_bus_cycles;
    cmd_t tbl[$];
    cmd_t c;
    int tp, bs_busy, bs_done0, bs_done1;
    logic [14:0] e;
    logic [6:0] oc;
    logic [7:0] ob, ord, erd;
`ifdef RTC_BUS_SEQ_CMD_QUEUE_EN
    bs_busy = 0; bs_done0 = 0; bs_done1 = 0;
`else
    bs_busy = 10; bs_done0 = 25; bs_done1 = 7;
`endif
    tbl.push_back('{0, 1'b1, 8'h21, 8'h29, 8'h00, 0});
    tbl.push_back('{0, 1'b0, 8'h16, 8'h00, 8'h29, 0});
    tbl.push_back('{0, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 0});
    tbl.push_back('{0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), bs_busy});
    tbl.push_back('{0, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), bs_done0});
    for (int i = 0; i < 4; i++)
      tbl.push_back('{0, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0});
    tbl.push_back('{1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 0});
    tbl.push_back('{1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), bs_done1});
    tbl.push_back('{1, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0});

    foreach (tbl[i]) begin
      c  = tbl[i];
      tp = (c.sel == 0) ? 4 : 1;
      cur_rv[c.sel] = c.rv;
      wr_nrd = c.wr; addr = c.a; wdata = c.d;
      if (c.sel == 0) start0 = 1'b1; else start1 = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 1; k <= 6 * tp + 3; k++) begin
        start0 = 1'b0; start1 = 1'b0;
        wr_nrd = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
        if (c.bs != 0 && k == c.bs) begin
          if (c.sel == 0) start0 = 1'b1; else start1 = 1'b1;
        end
        e   = exp_out(tp, k, c.wr, c.a, c.d);
        erd = (!c.wr && k > 5 * tp) ? c.rv : exp_rd[c.sel];
        if (c.sel == 0) begin oc = {busy0, done0, en0, cs0, ad0, rd0, wr0}; ob = bus0; ord = rdata0; end
        else            begin oc = {busy1, done1, en1, cs1, ad1, rd1, wr1}; ob = bus1; ord = rdata1; end
        n_checks++;
        if (oc !== e[14:8]) begin
          n_fail++;
          $display("FAIL ctrl cmd%0d cycle%0d: got %b expected %b (busy,done,EN_SS,CS_n,AD_n,RD_n,WR_n)", i, k, oc, e[14:8]);
        end
        n_checks++;
        if (ob !== e[7:0]) begin n_fail++; $display("FAIL bus_out cmd%0d cycle%0d: got %h expected %h", i, k, ob, e[7:0]); end
        n_checks++;
        if (ord !== erd) begin n_fail++; $display("FAIL rdata cmd%0d cycle%0d: got %h expected %h", i, k, ord, erd); end
        n_checks++;
        if (oc[4] === 1'b1 && oc[1] === 1'b0) begin n_fail++; $display("FAIL drive_during_read cmd%0d cycle%0d: EN_SS=1 with RD_n=0", i, k); end
        n_checks++;
        if (oc[1] === 1'b0 && oc[0] === 1'b0) begin n_fail++; $display("FAIL rd_wr_overlap cmd%0d cycle%0d: RD_n=0 with WR_n=0", i, k); end
        @(posedge clk);
        #1;
      end
      start0 = 1'b0; start1 = 1'b0;
      if (!c.wr) exp_rd[c.sel] = c.rv;
    end
  endtask

  task automatic test_reset_abort;
    int done_at, seen;
    cur_rv[0] = 8'hA5; wr_nrd = 1'b0; addr = 8'h33; wdata = 8'h00; start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (17) @(posedge clk);
    #3;
    n_checks++;
    if (rd0 !== 1'b0) begin n_fail++; $display("FAIL abort_in_strobe: RD_n got %b expected 0", rd0); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy0, done0, en0, cs0, ad0, rd0, wr0} !== 7'b0001111) begin
      n_fail++; $display("FAIL abort_ctrl: got %b expected 0001111", {busy0, done0, en0, cs0, ad0, rd0, wr0});
    end
    n_checks++;
    if (bus0 !== 8'h00) begin n_fail++; $display("FAIL abort_bus: got %h expected 00", bus0); end
    n_checks++;
    if (rdata0 !== 8'h00) begin n_fail++; $display("FAIL abort_rdata: got %h expected 00", rdata0); end
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done0 !== 1'b0 || busy0 !== 1'b0) seen++;
    end
    #3 rst_n = 1'b1;
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL abort_no_done: done/busy seen %0d cycles expected 0", seen); end
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    @(posedge clk);
    #1;
    cur_rv[0] = 8'h5A; addr = 8'h44; wr_nrd = 1'b0; start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    done_at = 0;
    for (int k = 1; k <= 40; k++) begin
      if (done0 === 1'b1 && done_at == 0) done_at = k;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (done_at != 25) begin n_fail++; $display("FAIL abort_restart_done: got cycle %0d expected 25", done_at); end
    n_checks++;
    if (rdata0 !== 8'h5A) begin n_fail++; $display("FAIL abort_restart_rdata: got %h expected 5a", rdata0); end
    exp_rd[0] = 8'h5A;
  endtask

`ifdef RTC_BUS_SEQ_CMD_QUEUE_EN
  task automatic test_queue;
    logic [14:0] e;
    logic [6:0]  oc;
    logic [7:0]  erd, rv;
    logic        eq;
    rv = 8'($urandom);
    cur_rv[0] = rv;
    wr_nrd = 1'b1; addr = 8'h10; wdata = 8'h01; start0 = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 52; k++) begin
      if (k == 5) begin
        start0 = 1'b1; wr_nrd = 1'b0; addr = 8'h11; wdata = 8'($urandom);
      end else begin
        start0 = 1'b0; wr_nrd = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
      end
      e   = (k <= 25) ? exp_out(4, k, 1'b1, 8'h10, 8'h01) : exp_out(4, k - 25, 1'b0, 8'h11, 8'h00);
      erd = (k > 45) ? rv : exp_rd[0];
      eq  = (k >= 6 && k <= 25);
      oc  = {busy0, done0, en0, cs0, ad0, rd0, wr0};
      n_checks++;
      if (oc !== e[14:8]) begin n_fail++; $display("FAIL q_ctrl cycle%0d: got %b expected %b", k, oc, e[14:8]); end
      n_checks++;
      if (bus0 !== e[7:0]) begin n_fail++; $display("FAIL q_bus_out cycle%0d: got %h expected %h", k, bus0, e[7:0]); end
      n_checks++;
      if (rdata0 !== erd) begin n_fail++; $display("FAIL q_rdata cycle%0d: got %h expected %h", k, rdata0, erd); end
      n_checks++;
      if (q_full0 !== eq) begin n_fail++; $display("FAIL q_full cycle%0d: got %b expected %b", k, q_full0, eq); end
      n_checks++;
      if (en0 === 1'b1 && rd0 === 1'b0) begin n_fail++; $display("FAIL q_drive_during_read cycle%0d", k); end
      @(posedge clk);
      #1;
    end
    start0 = 1'b0;
    exp_rd[0] = rv;
  endtask
`endif

  initial begin
    test_reset;
    test_bus_cycles;
    test_reset_abort;
`ifdef RTC_BUS_SEQ_CMD_QUEUE_EN
    test_queue;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
